processor_switches_poller: RTL and testbench

PROCESSOR_SWITCHES_POLLER -- requirements
Module: processor_switches_poller

---
 rtl/processor_switches_pkg.sv | 15 +
 rtl/processor_switches_debounce.sv | 48 ++++
 rtl/processor_switches_poller.sv | 127 ++++++++++++
 tb/tb_processor_switches_poller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_switches_pkg.sv
// Shared types and bus constants for the switches poller.
// Imported by the poller top and its debounce sub-module.
package processor_switches_pkg;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_UPDATE  = 2'd3
    } state_e;

    localparam logic [1:0]  PIO_DATA_ADDR = 2'd0;
    localparam int unsigned PIO_READ_LAT  = 1;

endpackage

// File: rtl/processor_switches_debounce.sv
// Switch debouncer: tracks a candidate value and its run length.
// Reports acceptance and the changed-bit delta against the current value.
module processor_switches_debounce #(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              upd_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic [DATA_W-1:0] value_i,
    output logic              accept_o,
    output logic [DATA_W-1:0] delta_o
);

    localparam logic [3:0] SC = 4'(STABLE_CNT);

    logic [DATA_W-1:0] cand_q, cand_d;
    logic [3:0]        cnt_q, cnt_d;

    // Extend the run on a repeat, restart it on a new value.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (sample_i == cand_q) begin
            cnt_d = (cnt_q >= SC) ? SC : cnt_q + 4'd1;
        end else begin
            cand_d = sample_i;
            cnt_d  = 4'd1;
        end
    end

    assign delta_o  = cand_d ^ value_i;
    assign accept_o = upd_i && (cnt_d >= SC)
                    && (cand_d != value_i);

    // Candidate and run length advance only on update strobes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cand_q <= '0;
            cnt_q  <= '0;
        end else if (upd_i) begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/processor_switches_poller.sv
// Periodic Avalon-MM poller of a switches PIO with debounce,
// sticky change mask and level interrupt.
module processor_switches_poller
    import processor_switches_pkg::*;
#(
    parameter int unsigned POLL_DIV   = 50000,
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned DATA_W     = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [1:0]        m_address,
    output logic              m_read,
    input  logic [31:0]       m_readdata,
    input  logic              clear_changed,
    output logic [DATA_W-1:0] sw_value,
    output logic [DATA_W-1:0] sw_changed,
    output logic              irq
);

    localparam logic [1:0] S_WAIT    = ST_WAIT;
    localparam logic [1:0] S_READ    = ST_READ;
    localparam logic [1:0] S_CAPTURE = ST_CAPTURE;
    localparam logic [1:0] S_UPDATE  = ST_UPDATE;

    // READ, the read-latency capture and UPDATE fill the rest
    // of each POLL_DIV period.
    localparam int unsigned WAIT_CYC =
        POLL_DIV - 2 - PIO_READ_LAT;
    localparam int unsigned TMR_W = $clog2(WAIT_CYC + 1);
    localparam logic [TMR_W-1:0] RELOAD  = TMR_W'(WAIT_CYC);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    logic [1:0]        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [DATA_W-1:0] sw_value_q, sw_value_d;
    logic [DATA_W-1:0] sw_changed_q, sw_changed_d;
    logic              irq_q;
    logic              m_read_q;
    logic              upd;
    logic              accept;
    logic [DATA_W-1:0] delta;

    if (DATA_W < 32) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^m_readdata[31:DATA_W];
    end

    // Poll sequencer with the wait down-counter.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            S_WAIT: begin
                if (!enable) begin
                    tmr_d = RELOAD;
                end else if (tmr_q <= TMR_ONE) begin
                    tmr_d   = RELOAD;
                    state_d = S_READ;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            S_READ:    state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_UPDATE;
            S_UPDATE:  state_d = S_WAIT;
            default:   state_d = S_WAIT;
        endcase
    end

    assign upd = (state_q == S_UPDATE);

    // Sample capture, accepted value and sticky change mask.
    always_comb begin
        sample_d = sample_q;
        if (state_q == S_CAPTURE) begin
            sample_d = m_readdata[DATA_W-1:0];
        end
        sw_value_d   = accept ? (sw_value_q ^ delta)
                              : sw_value_q;
        sw_changed_d = (clear_changed ? '0 : sw_changed_q)
                     | (accept ? delta : '0);
    end

    processor_switches_debounce #(
        .DATA_W     (DATA_W),
        .STABLE_CNT (STABLE_CNT)
    ) u_debounce (
        .clk      (clk),
        .reset_n  (reset_n),
        .upd_i    (upd),
        .sample_i (sample_q),
        .value_i  (sw_value_q),
        .accept_o (accept),
        .delta_o  (delta)
    );

    // State registers; reset abandons any poll in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_WAIT;
            tmr_q        <= RELOAD;
            sample_q     <= '0;
            sw_value_q   <= '0;
            sw_changed_q <= '0;
            irq_q        <= 1'b0;
            m_read_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            sample_q     <= sample_d;
            sw_value_q   <= sw_value_d;
            sw_changed_q <= sw_changed_d;
            irq_q        <= |sw_changed_d;
            m_read_q     <= (state_d == S_READ);
        end
    end

    assign m_address  = PIO_DATA_ADDR;
    assign m_read     = m_read_q;
    assign sw_value   = sw_value_q;
    assign sw_changed = sw_changed_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_processor_switches_poller.sv
// Bench for processor_switches_poller: directed scenarios plus
// randomized traffic against a behavioural poll/debounce model.
module tb_processor_switches_poller;

    localparam int PD = 8;
    localparam int SC = 3;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b1;
    logic [1:0]    m_address;
    logic          m_read;
    logic [31:0]   m_readdata = 32'h0;
    logic          clear_changed = 1'b0;
    logic [DW-1:0] sw_value;
    logic [DW-1:0] sw_changed;
    logic          irq;

    processor_switches_poller #(
        .POLL_DIV   (PD),
        .STABLE_CNT (SC),
        .DATA_W     (DW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_readdata    (m_readdata),
        .clear_changed (clear_changed),
        .sw_value      (sw_value),
        .sw_changed    (sw_changed),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int printed = 0;
    int cyc = 0;

    logic [DW-1:0] pio = '0;
    logic          force_ff = 1'b0;

    // model state
    int            m_phase = 0;
    int            m_waited = 0;
    logic [DW-1:0] m_samp = '0;
    logic [DW-1:0] m_val = '0;
    logic [DW-1:0] m_chg = '0;
    logic [DW-1:0] hist[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (printed < 60) begin
                printed++;
                $display("FAIL %s at cyc %0d: got %h, expected %h",
                         nm, cyc, act, exp);
            end
        end
    endtask

    always @(posedge clk) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // PIO slave: data is presented in the cycle after the read.
    initial begin
        logic       rd_prev;
        logic [31:0] r;
        rd_prev = 1'b0;
        forever begin
            @(negedge clk);
            r = $urandom;
            if (rd_prev) r[DW-1:0] = pio;
            m_readdata = force_ff ? 32'hFFFF_FFFF : r;
            rd_prev = m_read;
        end
    end

    // Behavioural model: a poll every PD cycles of enabled waiting,
    // accept when the last SC samples agree and differ.
    initial begin
        logic [DW-1:0] dl;
        bit same;
        forever begin
            @(posedge clk);
            dl = '0;
            if (!reset_n) begin
                m_phase = 0;
                m_waited = 0;
                m_samp = '0;
                m_val = '0;
                m_chg = '0;
                hist.delete();
            end else begin
                if (m_phase == 0) begin
                    if (enable) begin
                        m_waited++;
                        if (m_waited == PD - 3) begin
                            m_waited = 0;
                            m_phase = 1;
                        end
                    end else begin
                        m_waited = 0;
                    end
                end else if (m_phase == 1) begin
                    m_phase = 2;
                end else if (m_phase == 2) begin
                    m_samp = m_readdata[DW-1:0];
                    m_phase = 3;
                end else begin
                    hist.push_back(m_samp);
                    if (hist.size() > SC) void'(hist.pop_front());
                    same = (hist.size() == SC);
                    foreach (hist[i])
                        if (hist[i] != hist[0]) same = 0;
                    if (same && hist[0] != m_val) dl = hist[0] ^ m_val;
                    m_phase = 0;
                end
                m_chg = (clear_changed ? '0 : m_chg) | dl;
                m_val = m_val ^ dl;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_read", 32'(m_read), 32'(m_phase == 1));
            chk("m_address", 32'(m_address), 32'h0);
            chk("sw_value", 32'(sw_value), 32'(m_val));
            chk("sw_changed", 32'(sw_changed), 32'(m_chg));
            chk("irq", 32'(irq), 32'(m_chg != 0));
        end
    end

    task automatic wait_cyc(input int n);
        int k;
        k = 0;
        @(negedge clk);
        while (cyc != n && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (cyc != n) chk("wait_timeout", 32'(cyc), 32'(n));
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int nrd;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrd;
        pio = 10'h155;
        repeat (3) @(negedge clk);
        chk("rst_value", 32'(sw_value), 32'h0);
        chk("rst_read", 32'(m_read), 32'h0);
        reset_n = 1'b1;

        wait_cyc(4);  chk("rd_c4", 32'(m_read), 32'h0);
        wait_cyc(5);  chk("rd_c5", 32'(m_read), 32'h1);
        wait_cyc(13); chk("rd_c13", 32'(m_read), 32'h1);
        wait_cyc(16); chk("val_p2", 32'(sw_value), 32'h0);
        chk("chg_p2", 32'(sw_changed), 32'h0);
        wait_cyc(21); chk("rd_c21", 32'(m_read), 32'h1);
        wait_cyc(23); chk("val_c23", 32'(sw_value), 32'h0);
        wait_cyc(24);
        chk("val_p3", 32'(sw_value), 32'h155);
        chk("chg_p3", 32'(sw_changed), 32'h155);
        chk("irq_p3", 32'(irq), 32'h1);

        wait_cyc(25); pio = 10'h355;
        wait_cyc(47); clear_changed = 1'b1;
        wait_cyc(48); clear_changed = 1'b0;
        chk("val_clr", 32'(sw_value), 32'h355);
        chk("chg_clr", 32'(sw_changed), 32'h200);
        chk("irq_clr", 32'(irq), 32'h1);
        wait_cyc(51); clear_changed = 1'b1;
        wait_cyc(52); clear_changed = 1'b0;
        chk("chg_lone", 32'(sw_changed), 32'h0);
        chk("irq_lone", 32'(irq), 32'h0);

        wait_cyc(57); enable = 1'b0;
        nrd = 0;
        while (cyc < 77) begin
            @(negedge clk);
            if (m_read) nrd++;
        end
        enable = 1'b1;
        chk("rd_disabled", 32'(nrd), 32'h0);
        wait_cyc(81); chk("rd_c81", 32'(m_read), 32'h0);
        wait_cyc(82); chk("rd_reen", 32'(m_read), 32'h1);

        pio = 10'h001;
        do_reset(2);
        wait_cyc(9);  pio = 10'h000;
        wait_cyc(17); pio = 10'h001;
        wait_cyc(32); chk("bnc_c32", 32'(sw_value), 32'h0);
        wait_cyc(39); chk("bnc_c39", 32'(sw_value), 32'h0);
        wait_cyc(40); chk("bnc_c40", 32'(sw_value), 32'h001);

        wait_cyc(41); pio = 10'h2AA;
        wait_cyc(61); force_ff = 1'b1;
        wait_cyc(62); reset_n = 1'b0;
        @(negedge clk);
        chk("mrst_read", 32'(m_read), 32'h0);
        chk("mrst_val", 32'(sw_value), 32'h0);
        chk("mrst_chg", 32'(sw_changed), 32'h0);
        chk("mrst_irq", 32'(irq), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        force_ff = 1'b0;
        wait_cyc(5);  chk("mrst_rd5", 32'(m_read), 32'h1);
        wait_cyc(8);  chk("mrst_v8", 32'(sw_value), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0)
                pio = DW'($urandom_range(0, 1023));
            if ($urandom_range(0, 24) == 0) enable = ~enable;
            clear_changed = ($urandom_range(0, 19) == 0);
            reset_n = ($urandom_range(0, 599) != 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        enable = 1'b1;
        clear_changed = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
